// File: rtl/systolic_matvec_engine_pkg.sv
// Shared types and width helpers for the systolic matrix-vector engine.
package systolic_matvec_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SKEW_FEED,
        DRAIN,
        HOLD
    } state_t;

    // Width that holds a sum of n products of two data_width signed values.
    function automatic int acc_int_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_matvec_engine_pe.sv
// One multiply-accumulate cell: holds a weight, forwards x to the right and
// passes the running column sum downward.
module matvec_mac_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         w_load,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [PSUM_WIDTH-1:0] psum_in,
    output logic signed [DATA_WIDTH-1:0] x_out,
    output logic signed [PSUM_WIDTH-1:0] psum_out
);

    logic signed [DATA_WIDTH-1:0]   w_reg;
    logic signed [DATA_WIDTH-1:0]   x_reg;
    logic signed [PSUM_WIDTH-1:0]   psum_reg;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = x_in * w_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            w_reg    <= '0;
            x_reg    <= '0;
            psum_reg <= '0;
        end else begin
            if (w_load) begin
                w_reg <= w_in;
            end
            x_reg    <= x_in;
            psum_reg <= psum_in + PSUM_WIDTH'(prod);
        end
    end

    assign x_out    = x_reg;
    assign psum_out = psum_reg;

endmodule

// File: rtl/systolic_matvec_engine.sv
// N x N weight-stationary systolic array computing y = x^T * W with a
// valid/ready weight-load port, a vector input port and a held result port.
module systolic_matvec_engine
    import systolic_matvec_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int N          = 4,
    parameter int SATURATE   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [N*DATA_WIDTH-1:0]   w_row,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic [N*DATA_WIDTH-1:0]   x_vec,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [N*ACC_WIDTH-1:0]    y_vec,
    output logic                      weights_loaded
);

    localparam int IW = acc_int_width(DATA_WIDTH, N);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] CYC_FEED_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] CYC_DRAIN_LAST = CW'(2 * N - 1);
    localparam logic [RW-1:0] ROW_LAST       = RW'(N - 1);

    state_t                      state_reg;
    state_t                      state_next;
    logic [RW-1:0]               row_cnt_reg;
    logic [CW-1:0]               cyc_reg;
    logic                        wl_reg;
    logic [(N-1)*DATA_WIDTH-1:0] x_cap_reg;
    logic                        x_fire;
    logic                        w_fire;
    logic                        last_row;

    logic [N-1:0][N:0][DATA_WIDTH-1:0] x_link;
    logic [N:0][N-1:0][IW-1:0]         p_link;
    logic [N*DATA_WIDTH-1:0]           unused_x_tail;

    assign x_fire   = x_valid && x_ready;
    assign w_fire   = w_valid && w_ready;
    assign last_row = (row_cnt_reg == ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (x_valid && wl_reg) begin
                    state_next = SKEW_FEED;
                end else if (w_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_valid && last_row) begin
                    state_next = IDLE;
                end
            end
            SKEW_FEED: begin
                if (cyc_reg == CYC_FEED_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cyc_reg == CYC_DRAIN_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (y_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pending vector wins over a pending weight row, so the row is refused.
    always_comb begin
        x_ready = (state_reg == IDLE) && wl_reg;
        w_ready = ((state_reg == IDLE) && !(x_valid && wl_reg)) || (state_reg == LOAD);
        y_valid = (state_reg == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt_reg <= '0;
            cyc_reg     <= '0;
            wl_reg      <= 1'b0;
            x_cap_reg   <= '0;
        end else begin
            if (w_fire) begin
                row_cnt_reg <= last_row ? '0 : row_cnt_reg + RW'(1);
                wl_reg      <= last_row;
            end
            if (x_fire) begin
                x_cap_reg <= x_vec[N*DATA_WIDTH-1:DATA_WIDTH];
                cyc_reg   <= CW'(1);
            end else if (state_reg == SKEW_FEED) begin
                cyc_reg <= cyc_reg + CW'(1);
            end else if (state_reg == DRAIN) begin
                cyc_reg <= (cyc_reg == CYC_DRAIN_LAST) ? '0 : cyc_reg + CW'(1);
            end else begin
                cyc_reg <= '0;
            end
        end
    end

    assign weights_loaded = wl_reg;
    assign p_link[0]      = '0;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            // Row 0 is fed in the acceptance cycle itself, row gi gi cycles later.
            if (gi == 0) begin : g_feed0
                assign x_link[0][0] = x_fire ? x_vec[DATA_WIDTH-1:0] : '0;
            end else begin : g_feed
                assign x_link[gi][0] = ((state_reg == SKEW_FEED) && (cyc_reg == CW'(gi)))
                                     ? x_cap_reg[(gi-1)*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
            assign unused_x_tail[gi*DATA_WIDTH +: DATA_WIDTH] = x_link[gi][N];

            for (gj = 0; gj < N; gj++) begin : g_col
                matvec_mac_pe #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .PSUM_WIDTH (IW)
                ) u_pe (
                    .clk      (clk),
                    .srst     (reset),
                    .w_load   (w_fire && (row_cnt_reg == RW'(gi))),
                    .w_in     (w_row[gj*DATA_WIDTH +: DATA_WIDTH]),
                    .x_in     (x_link[gi][gj]),
                    .psum_in  (p_link[gi][gj]),
                    .x_out    (x_link[gi][gj+1]),
                    .psum_out (p_link[gi+1][gj])
                );
            end
        end

        for (gj = 0; gj < N; gj++) begin : g_out
            logic signed [IW-1:0]  col_sum;
            logic [ACC_WIDTH-1:0]  fit;
            logic [ACC_WIDTH-1:0]  y_reg;

            assign col_sum = p_link[N][gj];

            if (ACC_WIDTH >= IW) begin : g_extend
                assign fit = ACC_WIDTH'(col_sum);
            end else if (SATURATE != 0) begin : g_sat
                // Overflow when the discarded bits are not all copies of the sign.
                logic ovf;
                assign ovf = !((&col_sum[IW-1:ACC_WIDTH-1]) || ~(|col_sum[IW-1:ACC_WIDTH-1]));
                assign fit = !ovf ? col_sum[ACC_WIDTH-1:0]
                           : (col_sum[IW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(ACC_WIDTH-1){1'b1}}});
            end else begin : g_wrap
                logic unused_hi;
                assign unused_hi = ^col_sum[IW-1:ACC_WIDTH];
                assign fit       = col_sum[ACC_WIDTH-1:0];
            end

            // Column gj reaches the bottom row N+gj cycles after acceptance.
            always_ff @(posedge clk) begin
                if (reset) begin
                    y_reg <= '0;
                end else if ((state_reg == DRAIN) && (cyc_reg == CW'(N + gj))) begin
                    y_reg <= fit;
                end
            end

            assign y_vec[gj*ACC_WIDTH +: ACC_WIDTH] = y_reg;
        end
    endgenerate

endmodule
